// File: rtl/ysyx_25040109_trap_ctrl.sv
// ysyx_25040109_trap_ctrl
//   Owns the single write port of the machine-mode CSR file. Serialises
//   Zicsr read-modify-write ops, ecall/illegal trap entry and mret into at
//   most one CSR write per cycle, returns the old CSR value for rd and
//   issues PC redirects for trap entry/return.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   EXU request handshake (ready only in IDLE)
//   req_op/addr/src/...   request payload, latched on accept
//   csr_we/addr/wdata     CSR file write port (addr also drives the read)
//   csr_rdata             combinational read data for csr_addr
//   mstatus_i/mepc_i/mtvec_i  current CSR values
//   resp_valid/resp_rdata one-cycle completion pulse + old CSR value
//   redirect_valid/pc     PC redirect, coincident with resp_valid
//
// state    | meaning
// IDLE     | waiting for a request, req_ready high
// CSR_RMW  | read old value, write new value (csrrw/csrrs/csrrc)
// T_EPC    | trap entry: mepc <= pc
// T_CAUSE  | trap entry: mcause <= cause
// T_STATUS | trap entry: mstatus update, redirect to mtvec
// R_STATUS | mret: mstatus update, redirect to mepc
// DONE     | resp_valid (and redirect_valid for trap/mret)

module ysyx_25040109_trap_ctrl #(
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter logic [31:0] ILL_CAUSE   = 32'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_src,
  input  logic        req_src_x0,
  input  logic [31:0] req_pc,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mtvec_i,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CSR_RMW  = 3'd1;
  localparam logic [2:0] S_T_EPC    = 3'd2;
  localparam logic [2:0] S_T_CAUSE  = 3'd3;
  localparam logic [2:0] S_T_STATUS = 3'd4;
  localparam logic [2:0] S_R_STATUS = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [2:0]  r_op;
  logic [11:0] r_addr;
  logic [31:0] r_src;
  logic        r_src_x0;
  logic [31:0] r_pc;
  logic        r_redir;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_redirect_pc;
  logic        w_we;
  logic        w_accept;

  assign req_ready      = (r_state == S_IDLE);
  assign w_accept       = req_valid && req_ready;
  assign resp_valid     = (r_state == S_DONE);
  assign redirect_valid = (r_state == S_DONE) && r_redir;
  assign resp_rdata     = r_resp_rdata;
  assign redirect_pc    = r_redirect_pc;
  // Gated by rst so a reset landing mid-sequence suppresses that cycle's write.
  assign csr_we         = w_we && !rst;

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    csr_addr    = 12'h000;
    csr_wdata   = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_op <= OP_CSRRC)     w_state_nxt = S_CSR_RMW;
          else if (req_op == OP_MRET) w_state_nxt = S_R_STATUS;
          else                        w_state_nxt = S_T_EPC;
        end
      end
      S_CSR_RMW: begin
        csr_addr = r_addr;
        case (r_op)
          OP_CSRRS: csr_wdata = csr_rdata | r_src;
          OP_CSRRC: csr_wdata = csr_rdata & ~r_src;
          default:  csr_wdata = r_src;
        endcase
        // csrrs/csrrc with rs1=x0 / uimm=0 are pure reads.
        w_we        = (r_op == OP_CSRRW) || !r_src_x0;
        w_state_nxt = S_DONE;
      end
      S_T_EPC: begin
        w_we        = 1'b1;
        csr_addr    = 12'h341;
        csr_wdata   = r_pc;
        w_state_nxt = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        w_we        = 1'b1;
        csr_addr    = 12'h342;
        csr_wdata   = (r_op == OP_ECALL) ? ECALL_CAUSE : ILL_CAUSE;
        w_state_nxt = S_T_STATUS;
      end
      S_T_STATUS: begin
        // MPP=M, MPIE<=MIE, MIE<=0
        w_we        = 1'b1;
        csr_addr    = 12'h300;
        csr_wdata   = {mstatus_i[31:13], 2'b11, mstatus_i[10:8], mstatus_i[3],
                       mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
        w_state_nxt = S_DONE;
      end
      S_R_STATUS: begin
        // MPP stays M (M-only core), MIE<=MPIE, MPIE<=1
        w_we        = 1'b1;
        csr_addr    = 12'h300;
        csr_wdata   = {mstatus_i[31:13], 2'b11, mstatus_i[10:8], 1'b1,
                       mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};
        w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= 3'd0;
      r_addr        <= 12'h000;
      r_src         <= 32'h0;
      r_src_x0      <= 1'b0;
      r_pc          <= 32'h0;
      r_redir       <= 1'b0;
      r_resp_rdata  <= 32'h0;
      r_redirect_pc <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op     <= req_op;
        r_addr   <= req_addr;
        r_src    <= req_src;
        r_src_x0 <= req_src_x0;
        r_pc     <= req_pc;
        r_redir  <= (req_op >= OP_ECALL);
      end
      case (r_state)
        S_CSR_RMW:  r_resp_rdata <= csr_rdata;
        S_T_EPC:    r_resp_rdata <= 32'h0;
        S_T_STATUS: r_redirect_pc <= mtvec_i & ~32'h3;
        S_R_STATUS: begin
          r_resp_rdata  <= 32'h0;
          r_redirect_pc <= mepc_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ysyx_25040109_trap_ctrl.md
Name: ysyx_25040109_trap_ctrl

Overview:
Multi-cycle sequencer that owns the single write port of the machine-mode CSR file (mstatus/mtvec/mepc/mcause).
- Serialises Zicsr read-modify-write instructions, ecall trap entry and mret trap return into one CSR write per cycle.
- Returns the old CSR value for rd and issues PC redirects.
- Sits between EXU and the CSR register file.

Parameters:
- ECALL_CAUSE, 32'd11, mcause value written on ecall (M-mode environment call).
- ILL_CAUSE, 32'd2, mcause value written on illegal-instruction request.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  EXU request valid
- req_ready  out  1  high only in IDLE
- req_op  in  3  0=CSRRW 1=CSRRS 2=CSRRC 3=ECALL 4=MRET 5=ILLEGAL; 6,7 treated as ILLEGAL
- req_addr  in  12  CSR address (CSR ops only)
- req_src  in  32  rs1 value or zero-extended uimm
- req_src_x0  in  1  rs1/uimm field is zero
- req_pc  in  32  PC of requesting instruction
- csr_we  out  1  CSR file write enable
- csr_addr  out  12  CSR file address
- csr_wdata  out  32  CSR file write data
- csr_rdata  in  32  CSR file combinational read data
- mstatus_i  in  32  current mstatus
- mepc_i  in  32  current mepc
- mtvec_i  in  32  current mtvec
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  old CSR value for rd (0 for non-CSR ops)
- redirect_valid  out  1  PC redirect pulse, coincident with resp_valid
- redirect_pc  out  32  redirect target

Behaviour:
- Reset: state=IDLE; req_ready=1 (while IDLE); csr_we=0; csr_addr=0; csr_wdata=0; resp_valid=0; resp_rdata=0; redirect_valid=0; redirect_pc=0.
- Reset mid-sequence aborts: no further CSR writes, no resp pulse.
- Accept when req_valid && req_ready. On accept, latch op/addr/src/src_x0/pc; inputs are ignored until the next IDLE.
- States: IDLE, CSR_RMW, T_EPC, T_CAUSE, T_STATUS, R_STATUS, DONE.
- IDLE -> CSR_RMW (ops 0-2), T_EPC (ECALL/ILLEGAL), R_STATUS (MRET).
- CSR_RMW, one cycle:
  - csr_addr = latched addr; old = csr_rdata.
  - new = src (RW), old|src (RS), old&~src (RC).
  - csr_we = 1, except RS/RC with src_x0=1, where csr_we = 0.
  - resp_rdata <= old. -> DONE.
  - An unknown address still drives the write; the CSR file ignores it and returns 0.
- T_EPC: csr_we=1, addr 0x341, wdata=pc. -> T_CAUSE.
- T_CAUSE: addr 0x342, wdata=ECALL_CAUSE or ILL_CAUSE. -> T_STATUS.
- T_STATUS: addr 0x300; wdata = mstatus_i with MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)<=2'b11. -> DONE with redirect_pc <= {mtvec_i[31:2],2'b00}.
- R_STATUS: addr 0x300; wdata = mstatus_i with MIE<=MPIE, MPIE<=1, MPP<=2'b11 (M-only core). -> DONE with redirect_pc <= mepc_i.
- mtvec_i and mepc_i are sampled in the cycle of the state that sets redirect_pc.
- DONE:
  - csr_we=0; resp_valid=1.
  - redirect_valid=1 for trap/mret ops only.
  - resp_rdata=0 for trap/mret ops.
  - -> IDLE.
- Latency from the accept edge to the resp_valid cycle: CSR ops 2 cycles; MRET 2; ECALL/ILLEGAL 4.
- Back-to-back: a new request can be accepted in the cycle after DONE (req_ready=1 again).
- At most one csr_we per cycle. csr_we is never asserted in IDLE or DONE.
- Outputs of states that do not write: csr_addr/csr_wdata are don't-care, but must be held at 0 in IDLE.
- resp_valid has no backpressure; the consumer must accept the pulse.

Test Plan:
- Reset, then CSRRW addr 0x305 src 0x80000100 with mtvec=0 -> one csr_we to 0x305 data 0x80000100; resp_rdata=0; resp_valid 2 cycles after accept; no redirect.
- CSRRS 0x300 src 0x8 with mstatus=0x1800 -> write 0x1808, resp_rdata 0x1800. Repeat with src_x0=1 -> csr_we stays 0, resp_rdata 0x1800.
- CSRRC 0x300 src 0x1000 with mstatus=0x1808 -> write 0x0808.
- ECALL pc=0x80000040, mtvec=0x80000101, mstatus=0x1808 -> successive writes:
  - mepc=0x80000040
  - mcause=11
  - mstatus=0x1880
  - then redirect_valid with redirect_pc=0x80000100, 4 cycles after accept.
- MRET with mepc=0x80000044, mstatus=0x1880 -> mstatus write 0x1888; redirect 0x80000044. Also send an ILLEGAL op -> mcause=2.
- Assert rst in T_CAUSE of an ECALL -> no mcause/mstatus write, no resp_valid, req_ready=1 next cycle. Also hold req_valid during busy -> no second accept until after DONE.
